condlogic: RTL
==============

# condlogic

Conditional-execution unit for the multicycle ARM controller. It holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against the current flags. The result is registered once per instruction when the main FSM is in Decode. All architectural side effects (register write, memory write, PC write from branches, flag update) are then gated by that registered result. It sits between the main decoder/FSM and the datapath: it consumes decoder write requests and ALU flags, and produces the final write enables.

## Interface
Parameters:
- none (the flag width of 4 and cond width of 4 are architectural).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Cond  input  4  instruction bits [31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
- CondLoad  input  1  asserted by the FSM for exactly the Decode cycle; captures the evaluated condition.
- FlagW  input  2  flag write request: [1] writes N,Z; [0] writes C,V.
- PCS  input  1  decoder request: PC written by this instruction (branch or write to R15).
- NextPC  input  1  unconditional PC increment request (Fetch).
- RegW  input  1  register-file write request.
- MemW  input  1  memory write request.
- PCWrite  output  1  final PC write enable.
- RegWrite  output  1  final register write enable.
- MemWrite  output  1  final memory write enable.
- Flags  output  4  current {N,Z,C,V} register contents.
- CondExReg  output  1  registered condition result for the in-flight instruction.

## Operation
- CondEx (combinational, internal) follows ARM encoding on Flags:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 is treated as always (1).
- CondExReg: loads CondEx when CondLoad=1; otherwise holds.
- Flag register is split in two halves with independent enables:
  - FlagWrite[1] = FlagW[1] & CondExReg loads Flags[3:2] from ALUFlags[3:2].
  - FlagWrite[0] = FlagW[0] & CondExReg loads Flags[1:0] from ALUFlags[1:0].
- Outputs (combinational from requests and CondExReg):
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
  - PCWrite = NextPC | (PCS & CondExReg).
- While reset=1: RegWrite, MemWrite and PCWrite are forced to 0, and no flag or CondExReg update other than the reset load.
- There is no internal FSM; sequencing is owned by the main FSM. The block's state is Flags (4 b) and CondExReg (1 b).

## Timing
- Reset values after the reset edge: Flags=4'b0000, CondExReg=0, therefore PCWrite=NextPC, RegWrite=0, MemWrite=0.
- CondLoad in cycle t evaluates with the Flags visible in cycle t; CondExReg is valid from cycle t+1 for the rest of the instruction.
- Flag update requested in cycle t is visible on Flags in cycle t+1.
- If CondLoad and FlagWrite occur in the same cycle, CondEx uses the old flags (pre-edge); there is no bypass from ALUFlags.
- FlagW=2'b11 updates all four flags. FlagW=2'b10 leaves C,V unchanged. FlagW=2'b01 leaves N,Z unchanged.
- Failed condition (CondExReg=0): no flag, register, memory or branch-PC writes. NextPC still passes, so Fetch always advances.
- Reset asserted mid-instruction: at the next edge CondExReg=0 and Flags=0. Any writes pending in the reset cycle are suppressed.
- CondExReg holds across any number of cycles without CondLoad, for multi-cycle LDR/STR.

## Test plan
- Reset: hold reset with RegW=MemW=PCS=1 and NextPC=0 -> RegWrite=MemWrite=PCWrite=0. After release, Flags=0000 and CondExReg=0.
- Flag set and EQ: ALUFlags=0100, FlagW=11 with CondExReg=1 -> next cycle Flags=0100. Then Cond=0000 with CondLoad -> CondExReg=1 and RegW=1 gives RegWrite=1. Cond=0001 -> CondExReg=0 and RegWrite=0.
- Partial flag write: Flags=1111, ALUFlags=0000, FlagW=10 -> Flags=0011. Then FlagW=01 -> Flags=0000.
- Signed compares: Flags N=1,V=0 -> GE 0, LT 1, GT 0, LE 1. Flags Z=0,N=V=1 -> GT 1, LE 0. Cover all 16 Cond codes, with 1111 giving 1.
- Same-cycle hazard: Flags=0000, CondLoad with Cond=0000 and FlagW=11, ALUFlags=0100 in the same cycle -> CondExReg=0 (old Z) and Flags=0100 next.
- Suppressed branch: CondExReg=0, PCS=1, NextPC=0 -> PCWrite=0. With NextPC=1 -> PCWrite=1. With CondExReg=0 and FlagW=11 -> Flags unchanged.

Source files
------------

// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV flag register, condition evaluation,
// and gating of architectural write enables by the registered result.
module condlogic (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic       CondLoad,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic       CondExReg
);

   logic [3:0] flags_q, flags_d;
   logic       condex_q, condex_d;
   logic [1:0] flag_we;
   logic       cond_ex;
   logic       n, z, c, v;

   assign n = flags_q[3];
   assign z = flags_q[2];
   assign c = flags_q[1];
   assign v = flags_q[0];

   // Evaluated on the registered flags only; no ALUFlags bypass
   always_comb begin
      cond_ex = 1'b1;
      unique case (Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         4'b1111: cond_ex = 1'b1;
      endcase
   end

   assign flag_we = FlagW & {2{condex_q}};

   always_comb begin
      flags_d  = flags_q;
      condex_d = condex_q;
      if (flag_we[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_we[0]) flags_d[1:0] = ALUFlags[1:0];
      if (CondLoad)   condex_d     = cond_ex;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         flags_q  <= flags_d;
         condex_q <= condex_d;
      end
   end

   assign RegWrite  = ~reset & RegW & condex_q;
   assign MemWrite  = ~reset & MemW & condex_q;
   assign PCWrite   = ~reset & (NextPC | (PCS & condex_q));
   assign Flags     = flags_q;
   assign CondExReg = condex_q;

endmodule
